pipelined_controller: RTL and testbench

- Next-generation main control unit for the 5-stage pipelined RV32I core.
- Decodes the ID-stage opcode into the same control bundle as the single-cycle decoder.
- Adds LUI/AUIPC support and carries the bundle through ID/EX, EX/MEM and MEM/WB control registers, with stall and flush.
- Contains the load-use hazard detector, so the datapath only holds data registers; all control sequencing lives here.

---
 rtl/ctrl_pkg.sv | 49 ++++
 rtl/hazard_unit.sv | 26 ++
 rtl/pipelined_controller.sv | 172 +++++++++++++++++
 tb/tb_pipelined_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode, encoding and per-stage control bundle definitions
// for the pipelined RV32I main control unit.
package ctrl_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] IMM    = 7'b0010011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;
    localparam logic [1:0] MTR_IMM = 2'b11;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    typedef struct packed {
        logic       alusrc;
        logic       alusrca;
        logic [1:0] aluop;
        logic       branch;
        logic       jump;
        logic       jumpr;
        logic       illegal;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic       regwrite;
        logic [1:0] memtoreg;
    } wb_ctrl_t;

    localparam ex_ctrl_t  EX_ZERO  = '0;
    localparam mem_ctrl_t MEM_ZERO = '0;
    localparam wb_ctrl_t  WB_ZERO  = '0;

endpackage

// File: rtl/hazard_unit.sv
// Combinational load-use detector: a load in EX whose destination feeds
// the instruction in ID forces a one-cycle stall unless EX redirects.
module hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter bit EN_HAZARD  = 1'b1
) (
    input  logic                  id_valid,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_redirect,
    output logic                  stall
);

    logic hit;

    assign hit = ex_mem_read && (ex_rd != '0) &&
                 ((rs1_used && (ex_rd == id_rs1)) || (rs2_used && (ex_rd == id_rs2)));

    // A redirect kills the ID instruction anyway, so it must not also freeze the front end.
    assign stall = EN_HAZARD && id_valid && hit && !ex_redirect;

endmodule

// File: rtl/pipelined_controller.sv
// Main control unit for the 5-stage RV32I core: decodes ID, detects load-use,
// and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
module pipelined_controller
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter bit EN_UPPER   = 1'b1,
    parameter bit EN_HAZARD  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [6:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_redirect,
    output logic                  stall,
    output logic                  flush_ifid,
    output logic                  ex_alusrc,
    output logic                  ex_alusrca,
    output logic [1:0]            ex_aluop,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic                  ex_jumpr,
    output logic                  ex_illegal,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  wb_regwrite,
    output logic [1:0]            wb_memtoreg,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic [REG_ADDR_W-1:0] wb_rd
);

    ex_ctrl_t              ex_d;
    mem_ctrl_t             mem_d;
    wb_ctrl_t              wb_d;
    logic [REG_ADDR_W-1:0] rd_d;
    logic                  rs1_used;
    logic                  rs2_used;

    ex_ctrl_t              ex_e;
    mem_ctrl_t             mem_e;
    wb_ctrl_t              wb_e;
    logic [REG_ADDR_W-1:0] rd_e;
    mem_ctrl_t             mem_m;
    wb_ctrl_t              wb_m;
    logic [REG_ADDR_W-1:0] rd_m;
    wb_ctrl_t              wb_w;
    logic [REG_ADDR_W-1:0] rd_w;

    always_comb begin
        ex_d     = EX_ZERO;
        mem_d    = MEM_ZERO;
        wb_d     = WB_ZERO;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        rd_d     = id_valid ? id_rd : '0;
        if (id_valid) begin
            case (id_opcode)
                R_TYPE: begin
                    ex_d.aluop = ALUOP_R; wb_d.regwrite = 1'b1;
                    rs1_used = 1'b1; rs2_used = 1'b1;
                end
                LW: begin
                    ex_d.alusrc = 1'b1; mem_d.mem_read = 1'b1;
                    wb_d.regwrite = 1'b1; wb_d.memtoreg = MTR_MEM; rs1_used = 1'b1;
                end
                SW: begin
                    ex_d.alusrc = 1'b1; mem_d.mem_write = 1'b1;
                    rs1_used = 1'b1; rs2_used = 1'b1;
                end
                BR: begin
                    ex_d.branch = 1'b1; ex_d.aluop = ALUOP_BR;
                    rs1_used = 1'b1; rs2_used = 1'b1;
                end
                IMM: begin
                    ex_d.alusrc = 1'b1; ex_d.aluop = ALUOP_I;
                    wb_d.regwrite = 1'b1; rs1_used = 1'b1;
                end
                JAL: begin
                    ex_d.jump = 1'b1; wb_d.regwrite = 1'b1; wb_d.memtoreg = MTR_PC4;
                end
                JALR: begin
                    ex_d.jumpr = 1'b1; ex_d.alusrc = 1'b1;
                    wb_d.regwrite = 1'b1; wb_d.memtoreg = MTR_PC4; rs1_used = 1'b1;
                end
                LUI: begin
                    if (EN_UPPER) begin
                        ex_d.alusrc = 1'b1; wb_d.regwrite = 1'b1; wb_d.memtoreg = MTR_IMM;
                    end else begin
                        ex_d.illegal = 1'b1;
                    end
                end
                AUIPC: begin
                    if (EN_UPPER) begin
                        ex_d.alusrc = 1'b1; ex_d.alusrca = 1'b1;
                        wb_d.regwrite = 1'b1; wb_d.memtoreg = MTR_ALU;
                    end else begin
                        ex_d.illegal = 1'b1;
                    end
                end
                default: ex_d.illegal = 1'b1;
            endcase
        end
    end

    hazard_unit #(
        .REG_ADDR_W (REG_ADDR_W),
        .EN_HAZARD  (EN_HAZARD)
    ) u_hazard (
        .id_valid    (id_valid),
        .rs1_used    (rs1_used),
        .rs2_used    (rs2_used),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_mem_read (mem_e.mem_read),
        .ex_rd       (rd_e),
        .ex_redirect (ex_redirect),
        .stall       (stall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_e  <= EX_ZERO;
            mem_e <= MEM_ZERO;
            wb_e  <= WB_ZERO;
            rd_e  <= '0;
            mem_m <= MEM_ZERO;
            wb_m  <= WB_ZERO;
            rd_m  <= '0;
            wb_w  <= WB_ZERO;
            rd_w  <= '0;
        end else begin
            if (ex_redirect || stall) begin
                ex_e  <= EX_ZERO;
                mem_e <= MEM_ZERO;
                wb_e  <= WB_ZERO;
                rd_e  <= '0;
            end else begin
                ex_e  <= ex_d;
                mem_e <= mem_d;
                wb_e  <= wb_d;
                rd_e  <= rd_d;
            end
            mem_m <= mem_e;
            wb_m  <= wb_e;
            rd_m  <= rd_e;
            wb_w  <= wb_m;
            rd_w  <= rd_m;
        end
    end

    // Gated so every output reads 0 while reset is held, even with a redirect pending.
    assign flush_ifid  = ex_redirect && !reset;
    assign ex_alusrc   = ex_e.alusrc;
    assign ex_alusrca  = ex_e.alusrca;
    assign ex_aluop    = ex_e.aluop;
    assign ex_branch   = ex_e.branch;
    assign ex_jump     = ex_e.jump;
    assign ex_jumpr    = ex_e.jumpr;
    assign ex_illegal  = ex_e.illegal;
    assign ex_rd       = rd_e;
    assign mem_read    = mem_m.mem_read;
    assign mem_write   = mem_m.mem_write;
    assign mem_rd      = rd_m;
    assign wb_regwrite = wb_w.regwrite && (rd_w != '0);
    assign wb_memtoreg = wb_w.memtoreg;
    assign wb_rd       = rd_w;

endmodule

// File: tb/tb_pipelined_controller.sv
// Bench for pipelined_controller: directed scenarios then random traffic, both
// compared against a latency-based model of the instruction stream.
module tb_pipelined_controller;

    typedef struct packed {
        logic       alusrc;
        logic       alusrca;
        logic [1:0] aluop;
        logic       branch;
        logic       jump;
        logic       jumpr;
        logic       illegal;
        logic       mem_read;
        logic       mem_write;
        logic       regwrite;
        logic [1:0] memtoreg;
        logic [4:0] rd;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_redirect;

    logic       stall, flush_ifid, ex_alusrc, ex_alusrca, ex_branch, ex_jump, ex_jumpr, ex_illegal;
    logic       mem_read, mem_write, wb_regwrite;
    logic [1:0] ex_aluop, wb_memtoreg;
    logic [4:0] ex_rd, mem_rd, wb_rd;

    logic       n_stall, n_flush_ifid, n_ex_alusrc, n_ex_alusrca, n_ex_branch, n_ex_jump, n_ex_jumpr;
    logic       n_ex_illegal, n_mem_read, n_mem_write, n_wb_regwrite;
    logic [1:0] n_ex_aluop, n_wb_memtoreg;
    logic [4:0] n_ex_rd, n_mem_rd, n_wb_rd;

    int   n_cmp = 0;
    int   n_err = 0;
    ent_t q1[$];
    ent_t q2[$];
    logic [6:0] op_tab [10];

    always #5 clk = ~clk;

    pipelined_controller u_dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
        .stall(stall), .flush_ifid(flush_ifid), .ex_alusrc(ex_alusrc), .ex_alusrca(ex_alusrca),
        .ex_aluop(ex_aluop), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jumpr(ex_jumpr),
        .ex_illegal(ex_illegal), .mem_read(mem_read), .mem_write(mem_write),
        .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd)
    );

    pipelined_controller #(.EN_UPPER(1'b0)) u_dut_noupper (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
        .stall(n_stall), .flush_ifid(n_flush_ifid), .ex_alusrc(n_ex_alusrc), .ex_alusrca(n_ex_alusrca),
        .ex_aluop(n_ex_aluop), .ex_branch(n_ex_branch), .ex_jump(n_ex_jump), .ex_jumpr(n_ex_jumpr),
        .ex_illegal(n_ex_illegal), .mem_read(n_mem_read), .mem_write(n_mem_write),
        .wb_regwrite(n_wb_regwrite), .wb_memtoreg(n_wb_memtoreg),
        .ex_rd(n_ex_rd), .mem_rd(n_mem_rd), .wb_rd(n_wb_rd)
    );

    // What an instruction should carry once it is accepted into EX.
    function automatic ent_t decode(input logic v, input logic [6:0] op, input logic [4:0] rd,
                                    input bit en_up);
        ent_t e = '0;
        if (v) begin
            e.rd = rd;
            case (op)
                7'b0110011: begin e.regwrite = 1; e.aluop = 2'b10; end
                7'b0000011: begin e.alusrc = 1; e.mem_read = 1; e.regwrite = 1; e.memtoreg = 2'b01; end
                7'b0100011: begin e.alusrc = 1; e.mem_write = 1; end
                7'b1100011: begin e.branch = 1; e.aluop = 2'b01; end
                7'b0010011: begin e.alusrc = 1; e.regwrite = 1; e.aluop = 2'b11; end
                7'b1101111: begin e.jump = 1; e.regwrite = 1; e.memtoreg = 2'b10; end
                7'b1100111: begin e.jumpr = 1; e.alusrc = 1; e.regwrite = 1; e.memtoreg = 2'b10; end
                7'b0110111: if (en_up) begin e.alusrc = 1; e.regwrite = 1; e.memtoreg = 2'b11; end
                            else e.illegal = 1;
                7'b0010111: if (en_up) begin e.alusrc = 1; e.alusrca = 1; e.regwrite = 1; end
                            else e.illegal = 1;
                default:    e.illegal = 1;
            endcase
        end
        return e;
    endfunction

    function automatic logic exp_stall(input ent_t ex, input logic v, input logic [6:0] op,
                                       input logic [4:0] r1, input logic [4:0] r2, input logic redir);
        logic u1, u2;
        u1 = (op inside {7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b1100111});
        u2 = (op inside {7'b0110011, 7'b0100011, 7'b1100011});
        return v && !redir && ex.mem_read && (ex.rd != 0) &&
               ((u1 && ex.rd == r1) || (u2 && ex.rd == r2));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs1();
        return {2'b0, stall, flush_ifid, ex_alusrc, ex_alusrca, ex_aluop, ex_branch, ex_jump,
                ex_jumpr, ex_illegal, mem_read, mem_write, wb_regwrite, wb_memtoreg, ex_rd, mem_rd, wb_rd};
    endfunction

    function automatic logic [31:0] all_outs2();
        return {2'b0, n_stall, n_flush_ifid, n_ex_alusrc, n_ex_alusrca, n_ex_aluop, n_ex_branch, n_ex_jump,
                n_ex_jumpr, n_ex_illegal, n_mem_read, n_mem_write, n_wb_regwrite, n_wb_memtoreg,
                n_ex_rd, n_mem_rd, n_wb_rd};
    endfunction

    task automatic clear_model();
        q1 = {ent_t'(0), ent_t'(0), ent_t'(0)};
        q2 = {ent_t'(0), ent_t'(0), ent_t'(0)};
    endtask

    // Present one ID instruction, check all stages mid-cycle, then advance the model on the edge.
    task automatic cycle(input logic v, input logic [6:0] op, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd, input logic redir,
                         output logic stalled);
        logic s1, s2;
        id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd; ex_redirect = redir;
        @(negedge clk);
        s1 = exp_stall(q1[0], v, op, r1, r2, redir);
        s2 = exp_stall(q2[0], v, op, r1, r2, redir);
        check("stall", {31'b0, stall}, {31'b0, s1});
        check("flush", {31'b0, flush_ifid}, {31'b0, redir});
        check("ex", {19'b0, ex_alusrc, ex_alusrca, ex_aluop, ex_branch, ex_jump, ex_jumpr, ex_illegal, ex_rd},
              {19'b0, q1[0].alusrc, q1[0].alusrca, q1[0].aluop, q1[0].branch, q1[0].jump,
               q1[0].jumpr, q1[0].illegal, q1[0].rd});
        check("mem", {25'b0, mem_read, mem_write, mem_rd}, {25'b0, q1[1].mem_read, q1[1].mem_write, q1[1].rd});
        check("wb", {24'b0, wb_regwrite, wb_memtoreg, wb_rd},
              {24'b0, q1[2].regwrite && (q1[2].rd != 0), q1[2].memtoreg, q1[2].rd});
        check("nu_stall", {31'b0, n_stall}, {31'b0, s2});
        check("nu_ex", {19'b0, n_ex_alusrc, n_ex_alusrca, n_ex_aluop, n_ex_branch, n_ex_jump, n_ex_jumpr,
               n_ex_illegal, n_ex_rd},
              {19'b0, q2[0].alusrc, q2[0].alusrca, q2[0].aluop, q2[0].branch, q2[0].jump,
               q2[0].jumpr, q2[0].illegal, q2[0].rd});
        check("nu_wb", {24'b0, n_wb_regwrite, n_wb_memtoreg, n_wb_rd},
              {24'b0, q2[2].regwrite && (q2[2].rd != 0), q2[2].memtoreg, q2[2].rd});
        @(posedge clk);
        q1.push_front((redir || s1) ? ent_t'(0) : decode(v, op, rd, 1'b1));
        q2.push_front((redir || s2) ? ent_t'(0) : decode(v, op, rd, 1'b0));
        void'(q1.pop_back());
        void'(q2.pop_back());
        stalled = s1;
        #1;
    endtask

    initial begin
        logic st;
        op_tab = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011,
                   7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
        reset = 1'b1; id_valid = 0; id_opcode = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; ex_redirect = 0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", all_outs1(), 32'h0);
        check("reset_state_nu", all_outs2(), 32'h0);
        reset = 1'b0;

        // R-type add into x5, then bubbles to drain it to WB
        cycle(1, 7'b0110011, 5'd1, 5'd2, 5'd5, 0, st);
        repeat (3) cycle(0, 7'b0, 5'd0, 5'd0, 5'd0, 0, st);
        // load-use on x3: the consumer is re-presented while IF/ID is held
        cycle(1, 7'b0000011, 5'd1, 5'd0, 5'd3, 0, st);
        cycle(1, 7'b0110011, 5'd3, 5'd4, 5'd6, 0, st);
        check("lu_stall_seen", {31'b0, st}, 32'd1);
        cycle(1, 7'b0110011, 5'd3, 5'd4, 5'd6, 0, st);
        check("lu_stall_once", {31'b0, st}, 32'd0);
        // load into x0 never stalls a reader of x0
        cycle(1, 7'b0000011, 5'd1, 5'd0, 5'd0, 0, st);
        cycle(1, 7'b0110011, 5'd0, 5'd0, 5'd7, 0, st);
        check("x0_no_stall", {31'b0, st}, 32'd0);
        // redirect coinciding with a load-use condition
        cycle(1, 7'b0000011, 5'd1, 5'd0, 5'd4, 0, st);
        cycle(1, 7'b0110011, 5'd4, 5'd4, 5'd8, 1, st);
        check("redirect_wins", {31'b0, st}, 32'd0);
        // LUI then AUIPC, drained to WB
        cycle(1, 7'b0110111, 5'd0, 5'd0, 5'd9, 0, st);
        cycle(1, 7'b0010111, 5'd0, 5'd0, 5'd10, 0, st);
        repeat (3) cycle(0, 7'b0, 5'd0, 5'd0, 5'd0, 0, st);

        // three instructions in flight, then asynchronous reset mid-cycle
        cycle(1, 7'b0110011, 5'd1, 5'd2, 5'd11, 0, st);
        cycle(1, 7'b0010011, 5'd1, 5'd2, 5'd12, 0, st);
        cycle(1, 7'b0000011, 5'd1, 5'd2, 5'd13, 0, st);
        id_valid = 1; id_opcode = 7'b0110011; id_rs1 = 5'd13; ex_redirect = 1;
        #2 reset = 1'b1;
        #1;
        check("async_reset", all_outs1(), 32'h0);
        check("async_reset_nu", all_outs2(), 32'h0);
        @(posedge clk);
        #1;
        check("reset_held", all_outs1(), 32'h0);
        reset = 1'b0;
        clear_model();
        cycle(1, 7'b0110011, 5'd13, 5'd2, 5'd14, 0, st);
        repeat (3) cycle(0, 7'b0, 5'd0, 5'd0, 5'd0, 0, st);

        // random traffic with narrow register indices so hazards are frequent
        for (int i = 0; i < 300; i++) begin
            logic       v, redir;
            logic [6:0] op;
            logic [4:0] r1, r2, rd;
            int         guard;
            v     = ($urandom_range(0, 9) != 0);
            op    = op_tab[$urandom_range(0, 9)];
            r1    = 5'($urandom_range(0, 7));
            r2    = 5'($urandom_range(0, 7));
            rd    = 5'($urandom_range(0, 7));
            redir = ($urandom_range(0, 9) == 0);
            guard = 0;
            do begin
                cycle(v, op, r1, r2, rd, redir, st);
                guard++;
            end while (st && guard < 4);
            if (st) check("stall_bound", 32'd1, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
